// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: digit glyphs, symbol kinds and the
// "no symbol accepted yet" marker used by the receive side.
package seg7_pkg;

    localparam logic [6:0] SEG7_DIGIT0 = 7'h3F;
    localparam logic [6:0] SEG7_DIGIT1 = 7'h06;
    localparam logic [6:0] SEG7_DIGIT2 = 7'h5B;
    localparam logic [6:0] SEG7_DIGIT3 = 7'h4F;
    localparam logic [6:0] SEG7_DIGIT4 = 7'h66;
    localparam logic [6:0] SEG7_DIGIT5 = 7'h6D;
    localparam logic [6:0] SEG7_DIGIT6 = 7'h7D;
    localparam logic [6:0] SEG7_DIGIT7 = 7'h07;

    typedef enum logic [1:0] {
        KIND_DIGIT   = 2'b00,
        KIND_NONE    = 2'b01,
        KIND_INVALID = 2'b10,
        KIND_RSVD    = 2'b11
    } kind_e;

    typedef struct packed {
        kind_e      kind;
        logic [2:0] code;
    } sym_t;

    // The reserved kind is never produced by classification, so it cannot
    // match any real symbol.
    localparam sym_t SYM_UNKNOWN = '{kind: KIND_RSVD, code: 3'd0};

    typedef enum logic {
        ST_TRACK,
        ST_PRESENT
    } state_e;

    function automatic logic [6:0] seg7_digit(input logic [2:0] idx);
        logic [6:0] glyph;
        case (idx)
            3'd0:    glyph = SEG7_DIGIT0;
            3'd1:    glyph = SEG7_DIGIT1;
            3'd2:    glyph = SEG7_DIGIT2;
            3'd3:    glyph = SEG7_DIGIT3;
            3'd4:    glyph = SEG7_DIGIT4;
            3'd5:    glyph = SEG7_DIGIT5;
            3'd6:    glyph = SEG7_DIGIT6;
            default: glyph = SEG7_DIGIT7;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_classify.sv
// Combinational decode of a {dp, gfedcba} pattern into symbol kind and
// digit index; usable standalone as a display-bus checker.
module seg7_classify
    import seg7_pkg::*;
(
    input  logic [7:0] i_pattern,
    output kind_e      o_kind,
    output logic [2:0] o_code
);

    always_comb begin
        o_kind = KIND_INVALID;
        o_code = '0;
        if (i_pattern[7]) begin
            if (i_pattern[6:0] == 7'h00) begin
                o_kind = KIND_NONE;
            end
        end else begin
            for (int unsigned k = 0; k < 8; k++) begin
                if (i_pattern[6:0] == seg7_digit(3'(k))) begin
                    o_kind = KIND_DIGIT;
                    o_code = 3'(k);
                end
            end
        end
    end

endmodule

// File: rtl/seven_segment_to_priority_code.sv
// Recovers the priority code from a sampled 7-segment display bus, with
// input synchronisation, stability filtering and a valid/ready output.
module seven_segment_to_priority_code
    import seg7_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] segments,
    input  logic       no_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_kind,
    output logic [2:0] out_code,
    output logic [7:0] out_data,
    output logic       overrun,
    input  logic       overrun_clr
);

    localparam int unsigned    CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [7:0]       r_sync [SYNC_STAGES];
    logic [7:0]       r_prev;
    logic [CNT_W-1:0] r_cnt;
    sym_t             r_last;
    sym_t             r_out_sym;
    logic [7:0]       r_out_data;
    logic             r_overrun;
    state_e           r_state;
    state_e           w_state_next;

    logic [7:0] w_vec;
    logic       w_same;
    logic       w_stable;
    logic       w_new;
    logic       w_load;
    logic       w_drop;
    kind_e      w_kind;
    logic [2:0] w_code;
    sym_t       w_sym;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= {no_data, segments};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_vec  = r_sync[SYNC_STAGES-1];
    assign w_same = (w_vec == r_prev);
    // Fires only on the cycle the count reaches its limit, not while saturated.
    assign w_stable = w_same && (r_cnt == CNT_MAX - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_prev <= w_vec;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    seg7_classify u_classify (
        .i_pattern (w_vec),
        .o_kind    (w_kind),
        .o_code    (w_code)
    );

    assign w_sym = '{kind: w_kind, code: w_code};
    assign w_new = w_stable && (w_sym != r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_TRACK;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_TRACK:   if (w_new)     w_state_next = ST_PRESENT;
            ST_PRESENT: if (out_ready) w_state_next = ST_TRACK;
            default:                   w_state_next = ST_TRACK;
        endcase
    end

    always_comb begin
        out_valid = (r_state == ST_PRESENT);
        w_load    = (r_state == ST_TRACK) && w_new;
        w_drop    = (r_state == ST_PRESENT) && w_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_sym  <= '{kind: KIND_DIGIT, code: 3'd0};
            r_out_data <= '0;
            r_last     <= SYM_UNKNOWN;
            r_overrun  <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_sym  <= w_sym;
                r_out_data <= (w_sym.kind == KIND_DIGIT) ? (8'h01 << w_sym.code) : '0;
            end
            if (w_new) begin
                r_last <= w_sym;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_kind = r_out_sym.kind;
    assign out_code = r_out_sym.code;
    assign out_data = r_out_data;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_seven_segment_to_priority_code.sv
// Directed bench: expected symbols are queued when stimulus is applied and a
// monitor checks each transfer against the queue.
module tb_seven_segment_to_priority_code;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] code;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] segments;
    logic       no_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_kind;
    logic [2:0] out_code;
    logic [7:0] out_data;
    logic       overrun;
    logic       overrun_clr;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    seven_segment_to_priority_code #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .segments    (segments),
        .no_data     (no_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_kind    (out_kind),
        .out_code    (out_code),
        .out_data    (out_data),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dp, input logic [6:0] seg);
        no_data  = dp;
        segments = seg;
    endtask

    task automatic expect_sym(input logic [1:0] k, input logic [2:0] c, input logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.code = c;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Input already applied; reset released at a falling edge so the next
    // rising edge is E0 and out_valid must first be seen after E6.
    task automatic release_and_check_latency(input string name);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_lat_e%0d", name, i), {31'd0, out_valid}, {31'd0, (i == 6)});
        end
    endtask

    // Monitor: one transfer per cycle where valid and ready are both high.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                a.kind = out_kind;
                a.code = out_code;
                a.data = out_data;
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_event: got kind=%0d code=%0d data=%02h expected no event",
                             a.kind, a.code, a.data);
                end else begin
                    e = sb_q.pop_front();
                    check("event", {19'd0, a}, {19'd0, e});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t dropped;
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        drive(1'b0, 7'h3F);
        cycles(3);
        check("rst_valid",   {31'd0, out_valid}, 32'd0);
        check("rst_kind",    {30'd0, out_kind},  32'd0);
        check("rst_code",    {29'd0, out_code},  32'd0);
        check("rst_data",    {24'd0, out_data},  32'd0);
        check("rst_overrun", {31'd0, overrun},   32'd0);

        // Digit 0 after reset release, then a single-cycle handshake.
        expect_sym(2'b00, 3'd0, 8'h01);
        release_and_check_latency("d0");
        out_ready = 1'b1;
        cycles(1);
        check("d0_valid_drop", {31'd0, out_valid}, 32'd0);

        // Digit 7, a 2-cycle glitch to 6, back to 7: one event only.
        expect_sym(2'b00, 3'd7, 8'h80);
        drive(1'b0, 7'h07);
        cycles(12);
        drive(1'b0, 7'h7D);
        cycles(2);
        drive(1'b0, 7'h07);
        cycles(12);
        check("glitch_pending", sb_q.size(), 32'd0);

        // Blank display: none, and no repeat while held.
        expect_sym(2'b01, 3'd0, 8'h00);
        drive(1'b1, 7'h00);
        cycles(50);

        // Invalid patterns: an "8", then dp lit together with a segment.
        expect_sym(2'b10, 3'd0, 8'h00);
        drive(1'b0, 7'h7F);
        cycles(12);
        expect_sym(2'b00, 3'd2, 8'h04);
        drive(1'b0, 7'h5B);
        cycles(12);
        expect_sym(2'b10, 3'd0, 8'h00);
        drive(1'b1, 7'h06);
        cycles(12);
        check("inval_pending", sb_q.size(), 32'd0);

        // Held output with a second stable symbol: overrun, payload frozen.
        out_ready = 1'b0;
        expect_sym(2'b00, 3'd4, 8'h10);
        drive(1'b0, 7'h66);
        cycles(12);
        check("ovr_valid_held", {31'd0, out_valid}, 32'd1);
        check("ovr_before",     {31'd0, overrun},   32'd0);
        drive(1'b0, 7'h6D);
        cycles(12);
        check("ovr_set",     {31'd0, overrun},  32'd1);
        check("ovr_frozen",  {29'd0, out_code}, 32'd4);
        check("ovr_data",    {24'd0, out_data}, 32'h10);
        out_ready = 1'b1;
        cycles(3);
        check("ovr_after_xfer_valid", {31'd0, out_valid}, 32'd0);
        check("ovr_sticky",           {31'd0, overrun},   32'd1);
        overrun_clr = 1'b1;
        cycles(1);
        overrun_clr = 1'b0;
        check("ovr_cleared", {31'd0, overrun}, 32'd0);
        cycles(8);

        // Reset while presenting drops the symbol; it is re-emitted after release.
        out_ready = 1'b0;
        expect_sym(2'b00, 3'd3, 8'h08);
        drive(1'b0, 7'h4F);
        cycles(12);
        check("rst_mid_valid_before", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid",   {31'd0, out_valid}, 32'd0);
        check("rst_mid_kind",    {30'd0, out_kind},  32'd0);
        check("rst_mid_code",    {29'd0, out_code},  32'd0);
        check("rst_mid_data",    {24'd0, out_data},  32'd0);
        check("rst_mid_overrun", {31'd0, overrun},   32'd0);
        if (sb_q.size() != 0) dropped = sb_q.pop_front();
        expect_sym(2'b00, 3'd3, 8'h08);
        release_and_check_latency("re");
        out_ready = 1'b1;
        cycles(6);
        check("final_pending", sb_q.size(), 32'd0);
        check("final_valid", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_segment_to_priority_code.md
# seven_segment_to_priority_code

Receive-side counterpart of the priority-encoder / 7-segment driver. It samples the 8 display lines (segments gfedcba plus decimal point `no_data`) from an external or on-chip 7-segment interface and recovers the 3-bit priority code. Changes are accepted only after they have been stable for a set time, and each accepted symbol is presented on a valid/ready output. It sits where a display bus is looped back or monitored: self-test of the encoder path, or a second die reading the first.

## Interface
- `SYNC_STAGES`, 2, flops in the input synchronizer (≥2).
- `STABLE_CYCLES`, 4, consecutive synchronized cycles a pattern must hold before acceptance (≥1).
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `segments` in 7: display segments, bit6..0 = g f e d c b a, active-high, asynchronous to `clk`.
- `no_data` in 1: decimal-point line, high means "no input bit set".
- `out_valid` out 1: accepted symbol available.
- `out_ready` in 1: consumer takes the symbol on `out_valid & out_ready`.
- `out_kind` out 2: 00 digit, 01 none, 10 invalid, 11 reserved (never driven).
- `out_code` out 3: recovered index; 0 unless kind is digit.
- `out_data` out 8: minimal data word that re-encodes to the symbol: one-hot `1<<out_code` for a digit, 0 otherwise.
- `overrun` out 1: sticky; a symbol was dropped while the output was held.
- `overrun_clr` in 1: synchronous clear of `overrun`.

## Operation
- All 8 input lines pass through a `SYNC_STAGES` flop synchronizer. All further logic uses the synchronized vector `{dp, gfedcba}`.
- Classification:
  - dp=0 with segments equal to the digit table gives digit k. The table is 0:0x3F, 1:0x06, 2:0x5B, 3:0x4F, 4:0x66, 5:0x6D, 6:0x7D, 7:0x07.
  - dp=1 with segments=0 gives none.
  - Every other pattern gives invalid, including dp=1 with any segment lit.
- Stability counter:
  - Cleared whenever the synchronized vector differs from its value on the previous cycle.
  - Otherwise increments, saturating at `STABLE_CYCLES`.
  - The pattern is "stable" on the cycle the counter reaches `STABLE_CYCLES`.
- `last` register holds the last accepted classified symbol (kind + code). Reset value is UNKNOWN, so the first stable symbol after reset is always accepted.
- FSM states:
  - TRACK: waiting for stability. On stable with symbol ≠ `last`: load the output registers, set `last`, go to PRESENT. On stable with symbol = `last`: stay, no event.
  - PRESENT: `out_valid`=1 and the payload is frozen. On `out_ready`: go to TRACK.
  - In PRESENT, a newly stable symbol ≠ `last` is dropped. `last` is still updated and `overrun` is set.
- A glitch shorter than `STABLE_CYCLES` produces no event. A return to the same symbol as `last` produces no event.
- `overrun_clr` and a new overrun in the same cycle: set wins.

## Timing
- Reset values: `out_valid`=0, `out_kind`=00, `out_code`=0, `out_data`=0, `overrun`=0, counter=0, synchronizer flops=0, FSM=TRACK, `last`=UNKNOWN.
- Latency: an input held from before edge E0 gives `out_valid` high after edge E0+`SYNC_STAGES`+`STABLE_CYCLES`, which is edge 6 with defaults.
- Handshake:
  - `out_valid` is registered and never depends combinationally on `out_ready`.
  - The payload is stable while `out_valid`=1.
  - On a transfer, `out_valid` deasserts at the next edge.
  - Back-to-back symbols are spaced by at least `STABLE_CYCLES` cycles.
- `out_ready` high with `out_valid` low has no effect.
- `rst_n` asserted mid-PRESENT drops the pending symbol immediately (asynchronous). After release, the current input is re-accepted, because `last`=UNKNOWN.

## Structure
- Shared package `seg7_pkg`:
  - the digit table constants, the same ones the encoder side uses;
  - the `out_kind` enum values;
  - the UNKNOWN encoding for `last`.
- Sub-module `seg7_classify`: purely combinational, 8-bit pattern in, kind + code out. It is reusable for a lint/monitor checker.
- The top level holds the synchronizer, the stability counter, the FSM and the output registers.

## Test plan
- Reset release with `segments`=0x3F, dp=0 → after edge 6, `out_valid`=1, kind=00, code=0, `out_data`=0x01; ready=1 → `out_valid` drops next edge.
- Apply 0x07, dp=0, then 2-cycle glitch to 0x7D, then back to 0x07 → exactly one event, code=7, `out_data`=0x80, and no event for 6.
- dp=1, segments=0 → kind=01, code=0, `out_data`=0x00; hold 50 cycles → no second event.
- segments=0x7F, dp=0 (an "8") → kind=10 invalid; dp=1 with segments=0x06 → invalid as well.
- `out_ready`=0, present 0x66 (code 4), then 0x6D stable → payload stays code 4 and `overrun`=1; ready → transfer; `overrun_clr` → 0.
- Assert `rst_n`=0 while `out_valid`=1 → all outputs 0 immediately; on release with the input unchanged, the symbol is re-emitted after 6 edges.
